tmds_pll_seq: RTL
=================

Name: tmds_pll_seq

Overview:
- Reset/lock sequencer for the TMDS clock PLL (27 MHz in) of the HDMI output path.
- Pulses the PLL reset and debounces lock, then releases the clock-divider reset and the TMDS serializer reset in order.
- Detects lock loss and lock timeout, retries, and latches a failure after too many retries.
- Runs in the 27 MHz clkin domain; pll_lock is treated as asynchronous.

Parameters:
- PLL_RST_CYCLES, 16: cycles pll_reset is held high per reset attempt (≥2).
- LOCK_STABLE_CYCLES, 1024: consecutive synced-lock-high cycles required before release (≥1).
- LOCK_TIMEOUT_CYCLES, 270000: max cycles in WAIT_LOCK+STABLE before a retry (10 ms at 27 MHz).
- CLKDIV_DLY, 8: cycles between clkdiv_reset release and ser_reset release (≥1).
- MAX_RETRIES, 8: timeouts tolerated before FAIL (1..255).

Ports:
- clkin, in, 1: 27 MHz reference clock; the single clock of the block.
- reset, in, 1: synchronous, active-high reset.
- pll_lock, in, 1: PLL lock, asynchronous; passed through a 2-FF synchronizer (lock_s).
- restart_req, in, 1: single-cycle request to re-run the full sequence (e.g. after a video mode change).
- pll_reset, out, 1: drives the PLL RESET input.
- clkdiv_reset, out, 1: reset for the pixel-clock CLKDIV.
- ser_reset, out, 1: reset for the TMDS serializers/encoders.
- ready, out, 1: link clocks valid, serializer running.
- fail, out, 1: retry budget exhausted.
- lock_lost, out, 1: sticky; lock dropped while in RUN.
- retry_count, out, 8: number of lock timeouts since the last reset/FAIL-restart.
- state_o, out, 3: FSM state encoding: 0 PLL_RST, 1 WAIT_LOCK, 2 STABLE, 3 REL_DIV, 4 RUN, 5 FAIL.

Behaviour:
- All outputs are registered and derived from the state.
  - pll_reset=1 in PLL_RST and FAIL.
  - clkdiv_reset=0 only in REL_DIV and RUN.
  - ser_reset=0 and ready=1 only in RUN.
  - fail=1 only in FAIL.
- While reset=1:
  - state=PLL_RST, cycle counter=0, synchronizer flops=0.
  - pll_reset=1, clkdiv_reset=1, ser_reset=1, ready=0, fail=0, lock_lost=0, retry_count=0.
  - Reset asserted mid-sequence behaves identically; there is no partial release.
- PLL_RST:
  - pll_reset high for exactly PLL_RST_CYCLES cycles after entry, or after reset release.
  - Then goes to WAIT_LOCK, and the timeout counter clears.
- WAIT_LOCK:
  - lock_s=1 goes to STABLE, and the stable counter clears.
  - If the timeout counter reaches LOCK_TIMEOUT_CYCLES, retry_count increments. The FSM then goes to FAIL if the new value equals MAX_RETRIES, otherwise to PLL_RST.
- STABLE:
  - The stable counter increments each cycle lock_s=1.
  - lock_s=0 returns to WAIT_LOCK and clears the stable counter; the timeout counter keeps running.
  - Reaching LOCK_STABLE_CYCLES goes to REL_DIV.
  - Timeout applies here as in WAIT_LOCK.
- REL_DIV:
  - Held CLKDIV_DLY cycles, then goes to RUN.
  - lock_s=0 goes to PLL_RST without incrementing retry_count.
- RUN:
  - lock_s=0 sets lock_lost and goes to PLL_RST without incrementing retry_count.
- FAIL:
  - Parks with pll_reset=1.
  - restart_req clears retry_count and goes to PLL_RST.
- restart_req outside FAIL:
  - In any state other than PLL_RST, the FSM goes to PLL_RST on the next cycle and the PLL_RST counter restarts from 0.
  - It is ignored in PLL_RST.
  - It has priority over timeout (no retry increment) and over lock loss; lock_lost is still set if lock_s=0 in RUN on that cycle.
- Counters:
  - Sized with $clog2 of their terminal value.
  - retry_count saturates at 255; it is never reached, since MAX_RETRIES ≤255.
  - lock_lost clears only on reset.
- Latency: ready rises exactly 2 + LOCK_STABLE_CYCLES + CLKDIV_DLY cycles after pll_lock rises while in WAIT_LOCK.
- Release order: ready falls one cycle after lock_s falls in RUN. ser_reset and clkdiv_reset assert in that same cycle.

Test Plan:
All scenarios use PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, CLKDIV_DLY=3, MAX_RETRIES=2.
- Nominal bring-up: release reset, raise pll_lock 10 cycles later.
  - Required: pll_reset high exactly 4 cycles after release.
  - Required: clkdiv_reset falls 10 cycles, and ready/ser_reset change 13 cycles, after the pll_lock rise; retry_count=0.
- Glitchy lock: pll_lock high 5 cycles, low 2, then high.
  - Required: stable count restarts; ready rises 13 cycles after the final rise; no retry.
- Timeout/fail: pll_lock held 0.
  - Required: retry_count=1 after the first 32-cycle timeout, with a 4-cycle pll_reset pulse.
  - Required: after the second timeout, state_o=5, fail=1, pll_reset=1.
  - Then pulse restart_req: retry_count=0, state_o=0.
- Lock loss in RUN: drop pll_lock.
  - Required: within 3 cycles ready=0, ser_reset=1, clkdiv_reset=1, pll_reset=1, lock_lost=1.
  - Required: relock restores ready; lock_lost stays 1.
- Restart vs timeout: pulse restart_req on the exact timeout cycle.
  - Required: state_o=0 next cycle; retry_count unchanged.
- Reset mid-REL_DIV: assert reset for 1 cycle.
  - Required: all outputs return to reset values; the full sequence reruns.

Source files
------------

// File: rtl/tmds_pll_seq.sv
// -----------------------------------------------------------------------------
// tmds_pll_seq
// Reset/lock sequencer for the TMDS clock PLL of the HDMI output path.
// The sequence is: pulse the PLL reset, wait for lock, then require lock to
// stay high for a debounce window. After that, release the pixel-clock CLKDIV
// reset, and a little later the TMDS serializer reset. Lock loss and lock
// timeouts restart the sequence. Too many timeouts park the block in FAIL
// until restart_req is pulsed.
//
// Ports
//   clkin        in   27 MHz reference clock (only clock of the block)
//   reset        in   synchronous active-high reset
//   pll_lock     in   PLL lock, asynchronous (2-FF synchronised internally)
//   restart_req  in   single-cycle request to rerun the whole sequence
//   pll_reset    out  PLL RESET input
//   clkdiv_reset out  reset for the pixel-clock CLKDIV
//   ser_reset    out  reset for the TMDS serializers/encoders
//   ready        out  link clocks valid, serializer running
//   fail         out  retry budget exhausted
//   lock_lost    out  sticky: lock dropped while running
//   retry_count  out  lock timeouts since last reset / FAIL restart
//   state_o      out  0 PLL_RST, 1 WAIT_LOCK, 2 STABLE, 3 REL_DIV, 4 RUN, 5 FAIL
// -----------------------------------------------------------------------------
module tmds_pll_seq #(
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 270000,
  parameter int CLKDIV_DLY          = 8,
  parameter int MAX_RETRIES         = 8
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_lock,
  input  logic       restart_req,
  output logic       pll_reset,
  output logic       clkdiv_reset,
  output logic       ser_reset,
  output logic       ready,
  output logic       fail,
  output logic       lock_lost,
  output logic [7:0] retry_count,
  output logic [2:0] state_o
);

  // One shared counter serves the PLL_RST, STABLE and REL_DIV phases.
  localparam int CNT_MAX_A = (PLL_RST_CYCLES > CLKDIV_DLY) ? PLL_RST_CYCLES : CLKDIV_DLY;
  localparam int CNT_MAX   = (CNT_MAX_A > LOCK_STABLE_CYCLES) ? CNT_MAX_A : LOCK_STABLE_CYCLES;
  localparam int CW        = $clog2(CNT_MAX + 1);
  localparam int TW        = $clog2(LOCK_TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0] PRST_LAST = CW'(PLL_RST_CYCLES - 1);
  // The WAIT_LOCK cycle that first sees lock counts as the first stable
  // cycle, so STABLE itself only needs LOCK_STABLE_CYCLES-1 more.
  localparam logic [CW-1:0] STAB_LAST = CW'((LOCK_STABLE_CYCLES >= 2) ? LOCK_STABLE_CYCLES - 2 : 0);
  localparam logic [CW-1:0] DIV_LAST  = CW'(CLKDIV_DLY - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [7:0]    MAX_R     = 8'(MAX_RETRIES);

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_REL_DIV   = 3'd3,
    ST_RUN       = 3'd4,
    ST_FAIL      = 3'd5
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] to_q, to_d;
  logic [7:0]    retry_q, retry_d;
  logic          lost_q, lost_d;
  logic          sync1_q, lock_s_q;
  logic          pll_reset_q, clkdiv_reset_q, ser_reset_q, ready_q, fail_q;
  logic          timeout;

  assign timeout = (to_q == TO_LAST);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    retry_d = retry_q;
    lost_d  = lost_q;

    case (state_q)
      ST_PLL_RST: begin
        if (cnt_q == PRST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
          to_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_WAIT_LOCK, ST_STABLE: begin
        to_d = to_q + 1'b1;
        if (timeout) begin
          retry_d = (retry_q == 8'hFF) ? retry_q : retry_q + 8'd1;
          state_d = (retry_d == MAX_R) ? ST_FAIL : ST_PLL_RST;
          cnt_d   = '0;
        end else if (state_q == ST_WAIT_LOCK) begin
          if (lock_s_q) begin
            state_d = (LOCK_STABLE_CYCLES == 1) ? ST_REL_DIV : ST_STABLE;
            cnt_d   = '0;
          end
        end else if (!lock_s_q) begin
          // Glitch: restart debounce, but keep the timeout running.
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STAB_LAST) begin
          state_d = ST_REL_DIV;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_REL_DIV: begin
        if (!lock_s_q) begin
          state_d = ST_PLL_RST;
          cnt_d   = '0;
        end else if (cnt_q == DIV_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RUN: begin
        if (!lock_s_q) begin
          lost_d  = 1'b1;
          state_d = ST_PLL_RST;
          cnt_d   = '0;
        end
      end

      ST_FAIL: begin
        if (restart_req) begin
          retry_d = '0;
          state_d = ST_PLL_RST;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = ST_PLL_RST;
        cnt_d   = '0;
      end
    endcase

    // Restart overrides timeout and lock loss; lock_lost set above is kept.
    if (restart_req && (state_q != ST_PLL_RST) && (state_q != ST_FAIL)) begin
      state_d = ST_PLL_RST;
      cnt_d   = '0;
      retry_d = retry_q;
    end
  end

  // State, counters, synchronizer and output registers
  always_ff @(posedge clkin) begin
    if (reset) begin
      state_q        <= ST_PLL_RST;
      cnt_q          <= '0;
      to_q           <= '0;
      retry_q        <= '0;
      lost_q         <= 1'b0;
      sync1_q        <= 1'b0;
      lock_s_q       <= 1'b0;
      pll_reset_q    <= 1'b1;
      clkdiv_reset_q <= 1'b1;
      ser_reset_q    <= 1'b1;
      ready_q        <= 1'b0;
      fail_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      to_q           <= to_d;
      retry_q        <= retry_d;
      lost_q         <= lost_d;
      sync1_q        <= pll_lock;
      lock_s_q       <= sync1_q;
      // Outputs are registered from the next state so they track state_q.
      pll_reset_q    <= (state_d == ST_PLL_RST) || (state_d == ST_FAIL);
      clkdiv_reset_q <= !((state_d == ST_REL_DIV) || (state_d == ST_RUN));
      ser_reset_q    <= (state_d != ST_RUN);
      ready_q        <= (state_d == ST_RUN);
      fail_q         <= (state_d == ST_FAIL);
    end
  end

  assign pll_reset    = pll_reset_q;
  assign clkdiv_reset = clkdiv_reset_q;
  assign ser_reset    = ser_reset_q;
  assign ready        = ready_q;
  assign fail         = fail_q;
  assign lock_lost    = lost_q;
  assign retry_count  = retry_q;
  assign state_o      = state_q;

endmodule
